// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, line levels and
// default frame geometry. Optional parity support: UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS_DEF  = 8;
  localparam int unsigned UART_OVERSAMPLE_DEF = 16;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both stages reset to RESET_VAL so an idle-high line reads idle out of reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops resolve metastability on the raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx_in, qualifies the start bit at
// half-bit, samples data/parity/stop at mid-bit and emits each byte with a
// one-cycle rx_valid pulse plus framing/parity flags.
// Optional parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_framing_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic perr_q;
  assign rx_parity_err = perr_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign rx_parity_err     = 1'b0;
`endif

  uart_rx_sync #(
    .RESET_VAL(UART_IDLE_LVL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_in),
    .q    (rx_s)
  );

  // Frame FSM with tick/bit counters, shifter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_framing_err <= 1'b0;
      rx_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit        <= 1'b0;
      perr_q         <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_s == UART_START_LVL) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end

        ST_START: begin
          if (baud_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (rx_s == UART_START_LVL) begin
                rx_busy <= 1'b1;
                bit_cnt <= '0;
                state   <= ST_DATA;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= ST_PARITY;
`else
                state   <= ST_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif

        ST_STOP: begin
          if (baud_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt       <= '0;
              rx_data        <= shreg;
              rx_valid       <= 1'b1;
              rx_framing_err <= (rx_s != UART_STOP_LVL);
              rx_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
              perr_q         <= (par_bit != ((^shreg) ^ parity_odd));
`endif
              state          <= (rx_s == UART_STOP_LVL) ? ST_IDLE : ST_WAIT_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (rx_s == UART_IDLE_LVL) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer (8 data bits, 16x
// oversampling, baud_tick held high). Parity scenario built with
// UART_RX_PARITY_EN.
module tb_uart_rx_deframer;
  import uart_pkg::*;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b1;
  logic       rx_in = 1'b1;
  logic       parity_odd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_framing_err;
  logic       rx_parity_err;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  int         valid_cnt = 0;
  int         cap_cyc = 0;
  logic [7:0] cap_data [0:31];
  logic       cap_ferr [0:31];
  logic       cap_perr [0:31];
  logic       busy_seen = 1'b0;

  uart_rx_deframer #(
    .DATA_BITS (8),
    .OVERSAMPLE(OS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_tick     (baud_tick),
    .rx_in         (rx_in),
    .parity_odd    (parity_odd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_framing_err(rx_framing_err),
    .rx_parity_err (rx_parity_err),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_busy) busy_seen = 1'b1;
    if (rx_valid) begin
      cap_data[valid_cnt & 31] = rx_data;
      cap_ferr[valid_cnt & 31] = rx_framing_err;
      cap_perr[valid_cnt & 31] = rx_parity_err;
      cap_cyc = cyc;
      valid_cnt++;
    end
  end

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic line_bit(input logic b);
    rx_in = b;
    repeat (OS) @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the line high.
  task automatic send_byte(input logic [7:0] d, input logic par,
                           input logic stop_lvl, input int stop_bits);
    start_cyc = cyc;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    line_bit(par);
`else
    if (par === 1'bz) rx_in = 1'b1;
`endif
    for (int i = 0; i < stop_bits; i++) line_bit(stop_lvl);
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if ({rx_framing_err, rx_parity_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {rx_framing_err, rx_parity_err}); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int n0;
    n0 = valid_cnt;
    send_byte(8'hA5, even_par(8'hA5), 1'b1, 1);
    repeat (2 * OS) @(negedge clk);
    checks++; if (valid_cnt !== n0 + 1) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", valid_cnt - n0, 1); end
    checks++; if (cap_data[n0 & 31] !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", cap_data[n0 & 31]); end
    checks++; if (cap_ferr[n0 & 31] !== 1'b0) begin errors++; $display("FAIL basic_ferr got=%b exp=0", cap_ferr[n0 & 31]); end
    checks++; if (cap_perr[n0 & 31] !== 1'b0) begin errors++; $display("FAIL basic_perr got=%b exp=0", cap_perr[n0 & 31]); end
    checks++;
    if ((cap_cyc - start_cyc) < 153 || (cap_cyc - start_cyc) > 157) begin
      errors++; $display("FAIL basic_latency got=%0d exp=155", cap_cyc - start_cyc);
    end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", rx_busy); end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = valid_cnt;
    busy_seen = 1'b0;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * OS) @(negedge clk);
    checks++; if (valid_cnt !== n0) begin errors++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - n0); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", busy_seen); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_framing();
    int n0;
    n0 = valid_cnt;
    send_byte(8'h3C, even_par(8'h3C), 1'b0, 3);
    checks++; if (valid_cnt !== n0 + 1) begin errors++; $display("FAIL frame_count got=%0d exp=1", valid_cnt - n0); end
    checks++; if (cap_data[n0 & 31] !== 8'h3C) begin errors++; $display("FAIL frame_data got=%h exp=3c", cap_data[n0 & 31]); end
    checks++; if (cap_ferr[n0 & 31] !== 1'b1) begin errors++; $display("FAIL frame_ferr got=%b exp=1", cap_ferr[n0 & 31]); end
    checks++; if (rx_framing_err !== 1'b1) begin errors++; $display("FAIL frame_ferr_hold got=%b exp=1", rx_framing_err); end
    repeat (2 * OS) @(negedge clk);
    send_byte(8'h01, even_par(8'h01), 1'b1, 1);
    checks++; if (valid_cnt !== n0 + 2) begin errors++; $display("FAIL frame_next_count got=%0d exp=2", valid_cnt - n0); end
    checks++; if (cap_data[(n0 + 1) & 31] !== 8'h01) begin errors++; $display("FAIL frame_next_data got=%h exp=01", cap_data[(n0 + 1) & 31]); end
    checks++; if (cap_ferr[(n0 + 1) & 31] !== 1'b0) begin errors++; $display("FAIL frame_next_ferr got=%b exp=0", cap_ferr[(n0 + 1) & 31]); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int n0;
    n0 = valid_cnt;
    parity_odd = 1'b0;
    send_byte(8'h07, 1'b1, 1'b1, 1);
    repeat (OS) @(negedge clk);
    send_byte(8'h07, 1'b0, 1'b1, 1);
    repeat (OS) @(negedge clk);
    checks++; if (valid_cnt !== n0 + 2) begin errors++; $display("FAIL par_count got=%0d exp=2", valid_cnt - n0); end
    checks++; if (cap_perr[n0 & 31] !== 1'b0) begin errors++; $display("FAIL par_good got=%b exp=0", cap_perr[n0 & 31]); end
    checks++; if (cap_perr[(n0 + 1) & 31] !== 1'b1) begin errors++; $display("FAIL par_bad got=%b exp=1", cap_perr[(n0 + 1) & 31]); end
    checks++; if (cap_data[(n0 + 1) & 31] !== 8'h07) begin errors++; $display("FAIL par_data got=%h exp=07", cap_data[(n0 + 1) & 31]); end
  endtask
`endif

  task automatic test_midframe_reset();
    int n0;
    n0 = valid_cnt;
    fork
      send_byte(8'hFF, even_par(8'hFF), 1'b1, 1);
      begin
        repeat (OS * 5 + OS / 2) @(negedge clk);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got=%b exp=1", rx_busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", rx_busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", rx_data); end
        checks++; if ({rx_valid, rx_framing_err, rx_parity_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {rx_valid, rx_framing_err, rx_parity_err}); end
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (2 * OS) @(negedge clk);
    checks++; if (valid_cnt !== n0) begin errors++; $display("FAIL rst_no_valid got=%0d exp=0", valid_cnt - n0); end
    send_byte(8'h55, even_par(8'h55), 1'b1, 1);
    checks++; if (valid_cnt !== n0 + 1) begin errors++; $display("FAIL rst_next_count got=%0d exp=1", valid_cnt - n0); end
    checks++; if (cap_data[n0 & 31] !== 8'h55) begin errors++; $display("FAIL rst_next_data got=%h exp=55", cap_data[n0 & 31]); end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [7:0] exp_data [0:2];
    exp_data[0] = 8'h00;
    exp_data[1] = 8'hFF;
    exp_data[2] = 8'h81;
    n0 = valid_cnt;
    for (int i = 0; i < 3; i++) send_byte(exp_data[i], even_par(exp_data[i]), 1'b1, 1);
    repeat (2 * OS) @(negedge clk);
    checks++; if (valid_cnt !== n0 + 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", valid_cnt - n0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_data[(n0 + i) & 31] !== exp_data[i] || cap_ferr[(n0 + i) & 31] !== 1'b0 ||
          cap_perr[(n0 + i) & 31] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame%0d got=%h/%b/%b exp=%h/0/0", i, cap_data[(n0 + i) & 31],
                 cap_ferr[(n0 + i) & 31], cap_perr[(n0 + i) & 31], exp_data[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_midframe_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side counterpart of the UART transmit path.
- Synchronises the serial line, detects the start bit and samples each bit at mid-bit using an oversampling enable tick.
- Shifts in data LSB-first, checks the stop bit and presents each byte with a one-cycle valid pulse and error flags.
- Sits between the external RX pin and the byte consumer (FIFO/register interface).

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and at least 4.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- baud_tick  input  1  single-cycle enable; OVERSAMPLE pulses per bit time.
- rx_in  input  1  raw serial line; idle high, start=0, stop=1.
- parity_odd  input  1  1=odd parity, 0=even; used only with UART_RX_PARITY_EN.
- rx_data  output  DATA_BITS  last received byte.
- rx_valid  output  1  one-clk pulse when rx_data/flags updated.
- rx_framing_err  output  1  stop bit sampled low for this frame.
- rx_parity_err  output  1  parity mismatch for this frame (0 when feature off).
- rx_busy  output  1  high from start-bit acceptance until the frame ends.

Behaviour:
- Reset values while rst_n=0, asynchronous:
  - rx_data=0, rx_valid=0, both error flags 0, rx_busy=0.
  - Synchroniser flops = 1; state=IDLE; all counters 0.
- rx_in passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, giving 2 clk input latency.
- A tick counter (width clog2(OVERSAMPLE)) advances only on baud_tick. A bit counter (width clog2(DATA_BITS+1)) counts data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on rx_s==0 -> START, clear tick counter.
  - START: after OVERSAMPLE/2 ticks, resample.
    - rx_s==1: false start -> IDLE, no rx_valid, rx_busy drops.
    - rx_s==0: rx_busy=1, tick counter cleared -> DATA.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift rx_s into the MSB of the shift register (LSB-first on line). After DATA_BITS samples -> PARITY if the feature is enabled, else STOP.
  - PARITY: sample one bit after OVERSAMPLE ticks, then -> STOP.
  - STOP: sample after OVERSAMPLE ticks. In the same clk:
    - rx_data <= shift register, rx_valid=1 for exactly one clk.
    - rx_framing_err <= ~rx_s; rx_parity_err <= computed mismatch.
    - rx_s==1 -> IDLE; rx_s==0 -> WAIT_IDLE.
  - WAIT_IDLE: line held low (break or bad frame). Stay until rx_s==1, then -> IDLE. No further rx_valid is produced.
  - rx_busy deasserts on the clk rx_valid pulses.
- Error flags and rx_data hold their values until the next rx_valid. They are not sticky across frames.
- baud_tick absent: the FSM freezes in its current state; there is no timeout.
- Start edge in the same clk as the STOP exit is ignored. IDLE re-detects it on the next clk from rx_s, which is still 0.
- rst_n asserted mid-frame aborts immediately: partial byte discarded, no rx_valid.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state included.
  - Expected bit = XOR(data) ^ parity_odd.
  - rx_parity_err = sampled != expected.
  - Frame length = 1 start + DATA_BITS + 1 parity + 1 stop.
- Undefined:
  - PARITY state absent; FSM goes DATA -> STOP.
  - rx_parity_err tied 0; parity_odd unused.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (uart_rx_state_t).
  - Line-level constants: UART_IDLE_LVL=1, UART_START_LVL=0, UART_STOP_LVL=1.
  - Default DATA_BITS/OVERSAMPLE values.
- One sub-module: uart_rx_sync, the 2-flop synchroniser with reset value 1, reusable for other async inputs.
- FSM, counters and shifter stay in the top.

Test Plan:
1. Byte 8'hA5, 8N1, OVERSAMPLE=16, tick every clk:
   - One rx_valid, rx_data=8'hA5, framing_err=0.
   - rx_valid rises 2 + 16*9.5 ticks (± sync) after the start edge.
2. Glitch low for 4 ticks, then high:
   - No rx_valid, rx_busy stays 0, FSM back in IDLE.
3. Byte 8'h3C with stop bit driven 0 for 3 bit times, then high:
   - rx_valid once, rx_data=8'h3C, rx_framing_err=1.
   - Next frame 8'h01 accepted only after the line goes high; framing_err=0.
4. UART_RX_PARITY_EN, parity_odd=0:
   - Send 8'h07 with parity bit 1: parity_err=0.
   - Resend with parity bit 0: parity_err=1, data still 8'h07.
5. rst_n pulsed low during data bit 4 of 8'hFF:
   - All outputs 0 immediately, no rx_valid.
   - Subsequent 8'h55 received correctly.
6. Back-to-back frames 8'h00, 8'hFF, 8'h81 with no idle gap:
   - Three rx_valid pulses, values in order, no errors.
